// File: rtl/sevenseg_reader_if.sv
// Segment bus seen by the reader: scan inputs from the display side,
// decoded digit state back out.
interface sevenseg_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    sample_en;
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    update;
  logic                    frame_done;
  logic                    sel_err;

  modport master (
    output sample_en, seg_in, dig_sel,
    input  digits, digit_valid, digit_err,
    input  update, frame_done, sel_err
  );

  modport slave (
    input  sample_en, seg_in, dig_sel,
    output digits, digit_valid, digit_err,
    output update, frame_done, sel_err
  );
endinterface

// File: rtl/sevenseg_reader.sv
// 7-segment scan receiver: debounces each digit's pattern and
// decodes it back to a hex nibble, flagging illegal glyphs.
module sevenseg_reader #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 4
) (
  input logic              clk,
  input logic              rst_n,
  sevenseg_reader_if.slave bus
);

  localparam logic [CNT_W-1:0] STBL = CNT_W'(STABLE_CNT);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   last_sel_q, last_sel_d;
  logic [6:0]              last_seg_q, last_seg_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    update_q, update_d;
  logic                    frame_q, frame_d;
  logic                    selerr_q, selerr_d;

  logic       onehot;
  logic       same;
  logic       latch;
  logic [4:0] gl;

  // {hit, nibble}; exact match against the encoder's glyph set
  function automatic logic [4:0] glyph(input logic [6:0] s);
    unique case (s)
      7'h7E:   glyph = 5'h10;
      7'h30:   glyph = 5'h11;
      7'h6D:   glyph = 5'h12;
      7'h79:   glyph = 5'h13;
      7'h33:   glyph = 5'h14;
      7'h5B:   glyph = 5'h15;
      7'h5F:   glyph = 5'h16;
      7'h70:   glyph = 5'h17;
      7'h7F:   glyph = 5'h18;
      7'h7B:   glyph = 5'h19;
      7'h77:   glyph = 5'h1A;
      7'h1F:   glyph = 5'h1B;
      7'h4E:   glyph = 5'h1C;
      7'h3D:   glyph = 5'h1D;
      7'h4F:   glyph = 5'h1E;
      7'h47:   glyph = 5'h1F;
      default: glyph = 5'h00;
    endcase
  endfunction

  assign onehot = (bus.dig_sel != '0) &&
                  ((bus.dig_sel & (bus.dig_sel - ONE)) == '0);
  assign same   = (bus.dig_sel == last_sel_q) &&
                  (bus.seg_in == last_seg_q);
  assign gl     = glyph(bus.seg_in);

  always_comb begin
    cnt_d      = cnt_q;
    last_sel_d = last_sel_q;
    last_seg_d = last_seg_q;
    selerr_d   = 1'b0;
    if (bus.sample_en) begin
      if (!onehot) begin
        selerr_d   = 1'b1;
        cnt_d      = '0;
        last_sel_d = '0;
      end else if (same) begin
        cnt_d = (cnt_q < STBL) ? cnt_q + CNT_W'(1) : STBL;
      end else begin
        cnt_d      = CNT_W'(1);
        last_sel_d = bus.dig_sel;
        last_seg_d = bus.seg_in;
      end
    end
  end

  // One latch per stable run: only on the edge into saturation
  assign latch = bus.sample_en && onehot &&
                 (cnt_d == STBL) && (cnt_q < STBL);

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    seen_d   = seen_q;
    update_d = 1'b0;
    frame_d  = 1'b0;
    if (latch) begin
      update_d = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.dig_sel[i]) begin
          if (gl[4]) begin
            digits_d[4*i +: 4] = gl[3:0];
            valid_d[i]         = 1'b1;
            err_d[i]           = 1'b0;
          end else if (bus.seg_in == 7'h00) begin
            digits_d[4*i +: 4] = 4'h0;
            valid_d[i]         = 1'b0;
            err_d[i]           = 1'b0;
          end else begin
            valid_d[i] = 1'b0;
            err_d[i]   = 1'b1;
          end
        end
      end
      if (&(seen_q | bus.dig_sel)) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_q | bus.dig_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      last_sel_q <= '0;
      last_seg_q <= '0;
      seen_q     <= '0;
      digits_q   <= '0;
      valid_q    <= '0;
      err_q      <= '0;
      update_q   <= 1'b0;
      frame_q    <= 1'b0;
      selerr_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_sel_q <= last_sel_d;
      last_seg_q <= last_seg_d;
      seen_q     <= seen_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      update_q   <= update_d;
      frame_q    <= frame_d;
      selerr_q   <= selerr_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_err   = err_q;
  assign bus.update      = update_q;
  assign bus.frame_done  = frame_q;
  assign bus.sel_err     = selerr_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed bench for sevenseg_reader with an expected-latch queue
// checked whenever the reader pulses update.
module tb_sevenseg_reader;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  e;
    logic        f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sevenseg_reader_if #(.NUM_DIGITS(4)) bus ();

  sevenseg_reader #(
    .NUM_DIGITS(4),
    .STABLE_CNT(3),
    .CNT_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t sb[$];
  exp_t ex;
  int checks = 0;
  int fails  = 0;
  int upd_n  = 0;
  int frm_n  = 0;
  int se_n   = 0;
  int b_upd, b_frm, b_se;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.update === 1'b1) begin
      upd_n++;
      if (sb.size() == 0) begin
        chk("unexpected_update", 32'd1, 32'd0);
      end else begin
        ex = sb.pop_front();
        chk("latch_digits", 32'(bus.digits), 32'(ex.d));
        chk("latch_valid", 32'(bus.digit_valid), 32'(ex.v));
        chk("latch_err", 32'(bus.digit_err), 32'(ex.e));
        chk("latch_frame", 32'(bus.frame_done), 32'(ex.f));
      end
    end else if (bus.frame_done === 1'b1) begin
      chk("frame_without_update", 32'd1, 32'd0);
    end
    if (bus.frame_done === 1'b1) frm_n++;
    if (bus.sel_err === 1'b1) se_n++;
  end

  task automatic step(input logic en, input logic [3:0] sel,
                      input logic [6:0] seg);
    @(negedge clk);
    bus.sample_en = en;
    bus.dig_sel   = sel;
    bus.seg_in    = seg;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 7'h00);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] v,
                      input logic [3:0] e, input logic f);
    exp_t t;
    t.d = d; t.v = v; t.e = e; t.f = f;
    sb.push_back(t);
  endtask

  task automatic run3(input logic [3:0] sel, input logic [6:0] seg,
                      input bit gaps);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, sel, seg);
      if (gaps) step(1'b0, 4'h0, 7'h00);
    end
  endtask

  task automatic mark();
    b_upd = upd_n; b_frm = frm_n; b_se = se_n;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_digits"}, 32'(bus.digits), 32'd0);
    chk({tag, "_valid"}, 32'(bus.digit_valid), 32'd0);
    chk({tag, "_err"}, 32'(bus.digit_err), 32'd0);
    chk({tag, "_pulses"},
        32'({bus.update, bus.frame_done, bus.sel_err}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sample_en = 1'b0;
    bus.dig_sel   = '0;
    bus.seg_in    = '0;

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 4'($urandom), 7'($urandom));
    @(negedge clk);
    outs_zero("reset");
    rst_n = 1'b1;
    bus.sample_en = 1'b0;
    idle(3);
    outs_zero("post_reset_idle");

    // 2: digit 0 shows '1' for five samples
    mark();
    push(16'h0001, 4'b0001, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, 7'h30);
    idle(2);
    chk("t2_updates", 32'(upd_n - b_upd), 32'd1);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    chk("t2_digit0", 32'(bus.digits[3:0]), 32'h1);

    // 3: pattern change restarts the count
    mark();
    step(1'b1, 4'b0010, 7'h6D);
    step(1'b1, 4'b0010, 7'h6D);
    idle(1);
    chk("t3_no_early_latch", 32'(upd_n - b_upd), 32'd0);
    push(16'h0031, 4'b0011, 4'b0000, 1'b0);
    run3(4'b0010, 7'h79, 1'b0);
    idle(2);
    chk("t3_updates", 32'(upd_n - b_upd), 32'd1);
    chk("t3_digit1", 32'(bus.digits[7:4]), 32'h3);

    // 4: illegal glyph keeps nibble, blank clears it
    mark();
    push(16'h0531, 4'b0111, 4'b0000, 1'b0);
    run3(4'b0100, 7'h5B, 1'b0);
    push(16'h0531, 4'b0011, 4'b0100, 1'b0);
    run3(4'b0100, 7'h01, 1'b0);
    idle(2);
    chk("t4_err_nibble", 32'(bus.digits[11:8]), 32'h5);
    push(16'h0031, 4'b0011, 4'b0000, 1'b0);
    run3(4'b0100, 7'h00, 1'b0);
    idle(2);
    chk("t4_updates", 32'(upd_n - b_upd), 32'd3);
    chk("t4_frames", 32'(frm_n - b_frm), 32'd0);

    // 5: full frame twice, sample_en gaps between samples
    mark();
    push(16'h0038, 4'b0011, 4'b0000, 1'b0);
    run3(4'b0001, 7'h7F, 1'b1);
    push(16'h00A8, 4'b0011, 4'b0000, 1'b0);
    run3(4'b0010, 7'h77, 1'b1);
    push(16'h0CA8, 4'b0111, 4'b0000, 1'b0);
    run3(4'b0100, 7'h4E, 1'b1);
    push(16'hFCA8, 4'b1111, 4'b0000, 1'b1);
    run3(4'b1000, 7'h47, 1'b1);
    idle(2);
    chk("t5_frame1", 32'(frm_n - b_frm), 32'd1);
    push(16'hFCA8, 4'b1111, 4'b0000, 1'b0);
    run3(4'b0001, 7'h7F, 1'b1);
    push(16'hFCA8, 4'b1111, 4'b0000, 1'b0);
    run3(4'b0010, 7'h77, 1'b1);
    push(16'hFCA8, 4'b1111, 4'b0000, 1'b0);
    run3(4'b0100, 7'h4E, 1'b1);
    push(16'hFCA8, 4'b1111, 4'b0000, 1'b1);
    run3(4'b1000, 7'h47, 1'b1);
    idle(2);
    chk("t5_frames", 32'(frm_n - b_frm), 32'd2);
    chk("t5_updates", 32'(upd_n - b_upd), 32'd8);
    chk("t5_digits", 32'(bus.digits), 32'hFCA8);

    // 6: multi-hot select breaks the run
    mark();
    step(1'b1, 4'b0001, 7'h79);
    step(1'b1, 4'b0001, 7'h79);
    step(1'b1, 4'b0011, 7'h79);
    step(1'b1, 4'b0001, 7'h79);
    step(1'b1, 4'b0001, 7'h79);
    idle(2);
    chk("t6_sel_err", 32'(se_n - b_se), 32'd1);
    chk("t6_no_latch", 32'(upd_n - b_upd), 32'd0);
    push(16'hFCA3, 4'b1111, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 7'h79);
    idle(2);
    chk("t6_latch", 32'(upd_n - b_upd), 32'd1);

    // 6b: reset mid-run discards the count
    step(1'b1, 4'b0010, 7'h30);
    step(1'b1, 4'b0010, 7'h30);
    @(negedge clk);
    rst_n = 1'b0;
    bus.sample_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    outs_zero("mid_reset");
    mark();
    step(1'b1, 4'b0010, 7'h30);
    idle(2);
    chk("t6_reset_no_latch", 32'(upd_n - b_upd), 32'd0);
    push(16'h0010, 4'b0010, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 7'h30);
    step(1'b1, 4'b0010, 7'h30);
    idle(2);
    chk("t6_reset_relatch", 32'(upd_n - b_upd), 32'd1);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_reader.md
Name: sevenseg_reader

Overview:
- Receive side of the 7-segment display interface. Samples a multiplexed segment bus (segment pattern plus one-hot digit select) and reconstructs the hex nibble shown on each digit.
- Filters scan glitches with a consecutive-sample stability counter.
- Flags patterns that are not valid hex glyphs.
- Used as a display monitor/loopback checker for the hex-to-segment encoder and digit scanner.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, 1..8.
- STABLE_CNT, 3: consecutive identical samples required before a digit is latched, 1..15.
- CNT_W, 4: stability counter width; must hold STABLE_CNT.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- sample_en  input  1  sample strobe; seg_in/dig_sel are considered only when 1.
- seg_in  input  7  segment pattern {a,b,c,d,e,f,g}, bit 6 = a, active-high.
- dig_sel  input  NUM_DIGITS  digit select, one-hot, active-high; bit i = digit i.
- digits  output  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i].
- digit_valid  output  NUM_DIGITS  digit i holds a valid decoded glyph.
- digit_err  output  NUM_DIGITS  last latched pattern on digit i was not a legal glyph.
- update  output  1  one-cycle pulse on any digit latch.
- frame_done  output  1  one-cycle pulse when every digit has latched since the previous frame_done.
- sel_err  output  1  one-cycle pulse on a sample with non-one-hot dig_sel.

Behaviour:
- Reset (rst_n=0 at an edge): digits, digit_valid, digit_err, update, frame_done, sel_err, stability count, last_sel, last_seg and seen mask all become 0. Reset mid-run discards any partial count.
- Glyph table (hex value: seg_in): 0:7E, 1:30, 2:6D, 3:79, 4:33, 5:5B, 6:5F, 7:70, 8:7F, 9:7B, A:77, b:1F, C:4E, d:3D, E:4F, F:47. Exact 7-bit match only.
- When sample_en=0, all state holds; update, frame_done and sel_err are 0.
- Sample with one-hot dig_sel:
  - If dig_sel==last_sel and seg_in==last_seg: cnt <= min(cnt+1, STABLE_CNT).
  - Otherwise: cnt <= 1; last_sel <= dig_sel; last_seg <= seg_in.
- Latch event: the new cnt value equals STABLE_CNT and the old cnt was below STABLE_CNT. This gives exactly one latch per stable run; a saturated count does not re-latch.
- Latch is applied at the same edge as the count update, so outputs are visible in the cycle after the STABLE_CNT-th consecutive sample_en cycle.
- On latch for digit i:
  - Pattern in table: digits[i] <= value, valid[i] <= 1, err[i] <= 0.
  - Pattern 00 (blank): digits[i] <= 0, valid[i] <= 0, err[i] <= 0.
  - Any other pattern: digits[i] unchanged, valid[i] <= 0, err[i] <= 1.
  - In all three cases: update <= 1 and seen[i] <= 1.
- frame_done: if (seen | onehot(i)) is all ones at a latch, frame_done <= 1 and seen <= 0 at that same edge.
- Sample with zero or multi-hot dig_sel: sel_err <= 1, cnt <= 0, last_sel <= 0. No latch; digit outputs unchanged.
- Returning to the same digit after a different digit was selected restarts the count from 1.

Test Plan:
1. rst_n=0 for 2 cycles with random inputs -> all outputs 0. Release rst_n with sample_en=0 -> outputs stay 0.
2. Defaults; dig_sel=0001, seg_in=30 for 5 sample cycles:
   - digits[3:0]=1 and digit_valid[0]=1 one cycle after the 3rd sample.
   - update pulses exactly once.
   - no pulse on the 4th/5th samples.
3. Digit 1 with seg_in 6D, 6D, 79, 79, 79 -> no latch after the two 6D samples. digits[7:4]=3 after the 3rd 79; update single pulse.
4. Digit 2 with seg_in=01 x3 after a prior valid 5 -> digit_err[2]=1, digit_valid[2]=0, digits[11:8] remains 5. Then 00 x3 -> digits[11:8]=0, valid=0, err=0.
5. Digits 0..3 each with 7F, 77, 4E, 47 for 3 samples (sample_en gaps inserted) -> digits=16'hFCA8, digit_valid=4'hF, frame_done one pulse coincident with the 4th update. A second identical frame -> a second frame_done.
6. Digit 0 seg 79 x2, then dig_sel=0011 x1, then 79 x2 -> sel_err one pulse, no latch. A 3rd 79 -> latch. Asserting rst_n=0 after 2 samples of a run -> count discarded, no latch on the next single sample.
